// File: rtl/ll_pkg.sv
// Shared types for the linked-list pointer subsystem (builder, walker, start generator).
// Node 0 is the null pointer and terminates every chain.
package ll_pkg;

    localparam int unsigned N     = 16;
    localparam int unsigned W_PTR = $clog2(N);

    typedef logic [W_PTR-1:0] ptr_t;

    localparam ptr_t NULL_PTR = '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OPEN,
        ST_TERM
    } bld_state_e;

endpackage

// File: rtl/ll_free_fifo.sv
// Free-node pool: a ring of N pointers, preloaded with nodes 1..N-1 on reset.
// Null frees are ignored; a free into a full ring is dropped and flagged sticky.
module ll_free_fifo #(
    parameter int N     = 16,
    parameter int W_PTR = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pop_i,
    input  logic             push_vld_i,
    input  logic [W_PTR-1:0] push_ptr_i,
    output logic [W_PTR-1:0] head_o,
    output logic [W_PTR:0]   cnt_o,
    output logic             overflow_o
);

    logic [W_PTR-1:0] mem_q [N];
    logic [W_PTR-1:0] rd_q;
    logic [W_PTR-1:0] wr_q;
    logic [W_PTR:0]   cnt_q;
    logic             ovf_q;

    logic push_req;
    logic full;
    logic push_ok;

    assign push_req = push_vld_i && (push_ptr_i != '0);
    assign full     = (cnt_q == (W_PTR+1)'(N));
    assign push_ok  = push_req && !full;

    assign head_o     = mem_q[rd_q];
    assign cnt_o      = cnt_q;
    assign overflow_o = ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N; i++) begin
                mem_q[i] <= W_PTR'((i + 1) % N);
            end
            rd_q  <= '0;
            wr_q  <= W_PTR'(N - 1);
            cnt_q <= (W_PTR+1)'(N - 1);
            ovf_q <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= push_ptr_i;
                wr_q        <= wr_q + W_PTR'(1);
            end
            if (pop_i) begin
                rd_q <= rd_q + W_PTR'(1);
            end
            case ({push_ok, pop_i})
                2'b10:   cnt_q <= cnt_q + (W_PTR+1)'(1);
                2'b01:   cnt_q <= cnt_q - (W_PTR+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (push_req && full) begin
                ovf_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ll_list_builder.sv
// Writer side of the linked-list subsystem: allocates nodes, threads them through the
// next-pointer table and publishes each terminated chain's head to the walker.
module ll_list_builder
    import ll_pkg::*;
#(
    parameter int N     = 16,
    parameter int W_PTR = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic             in_last,
    output logic             in_rdy,
    output logic [W_PTR-1:0] alloc_ptr,
    output logic             nxt_we,
    output logic [W_PTR-1:0] nxt_waddr,
    output logic [W_PTR-1:0] nxt_wdata,
    output logic [W_PTR-1:0] start,
    output logic             start_vld,
    input  logic             start_rdy,
    input  logic [W_PTR-1:0] free_ptr,
    input  logic             free_vld,
    output logic [W_PTR:0]   free_cnt,
    output logic             err_overflow
);

    bld_state_e       state_q;
    logic [W_PTR-1:0] head_q;
    logic [W_PTR-1:0] tail_q;
    logic [W_PTR-1:0] start_q;
    logic             start_vld_q;
    logic             accept;

    ll_free_fifo #(
        .N     (N),
        .W_PTR (W_PTR)
    ) u_pool (
        .clk        (clk),
        .rst        (rst),
        .pop_i      (accept),
        .push_vld_i (free_vld),
        .push_ptr_i (free_ptr),
        .head_o     (alloc_ptr),
        .cnt_o      (free_cnt),
        .overflow_o (err_overflow)
    );

    assign in_rdy    = (state_q != ST_TERM) && (free_cnt != '0);
    assign accept    = in_vld && in_rdy;
    assign start     = start_q;
    assign start_vld = start_vld_q;

    // Table writes are combinational so the link lands on the same edge as the accept.
    always_comb begin
        nxt_we    = 1'b0;
        nxt_waddr = '0;
        nxt_wdata = '0;
        if (state_q == ST_OPEN && accept) begin
            nxt_we    = 1'b1;
            nxt_waddr = tail_q;
            nxt_wdata = alloc_ptr;
        end else if (state_q == ST_TERM) begin
            nxt_we    = 1'b1;
            nxt_waddr = tail_q;
            nxt_wdata = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            start_q     <= '0;
            start_vld_q <= 1'b0;
        end else begin
            if (start_vld_q && start_rdy) begin
                start_vld_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        head_q  <= alloc_ptr;
                        tail_q  <= alloc_ptr;
                        state_q <= in_last ? ST_TERM : ST_OPEN;
                    end
                end
                ST_OPEN: begin
                    if (accept) begin
                        tail_q <= alloc_ptr;
                        if (in_last) begin
                            state_q <= ST_TERM;
                        end
                    end
                end
                ST_TERM: begin
                    // Publish only once the terminator write is issued this cycle.
                    if (!start_vld_q || start_rdy) begin
                        start_q     <= head_q;
                        start_vld_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ll_list_builder.sv
// Self-checking bench for ll_list_builder: directed scenarios then random traffic,
// checked against a queue-based model of pool, open list and published chains.
module tb_ll_list_builder;

    localparam int N = 16;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_vld;
    logic         in_last;
    logic         in_rdy;
    logic [W-1:0] alloc_ptr;
    logic         nxt_we;
    logic [W-1:0] nxt_waddr;
    logic [W-1:0] nxt_wdata;
    logic [W-1:0] start;
    logic         start_vld;
    logic         start_rdy;
    logic [W-1:0] free_ptr;
    logic         free_vld;
    logic [W:0]   free_cnt;
    logic         err_overflow;

    always #5 clk = ~clk;

    ll_list_builder #(
        .N     (N),
        .W_PTR (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_vld       (in_vld),
        .in_last      (in_last),
        .in_rdy       (in_rdy),
        .alloc_ptr    (alloc_ptr),
        .nxt_we       (nxt_we),
        .nxt_waddr    (nxt_waddr),
        .nxt_wdata    (nxt_wdata),
        .start        (start),
        .start_vld    (start_vld),
        .start_rdy    (start_rdy),
        .free_ptr     (free_ptr),
        .free_vld     (free_vld),
        .free_cnt     (free_cnt),
        .err_overflow (err_overflow)
    );

    // The next-pointer table lives outside the builder.
    logic [W-1:0] tbl [N];
    always @(posedge clk) begin
        if (nxt_we) tbl[nxt_waddr] <= nxt_wdata;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    int pool[$];
    int cur[$];
    int closed_list[$];
    int pub_list[$];
    int consumed[$];
    bit closed;
    bit pub_valid;
    bit ovf;
    bit just_pub;

    task automatic model_reset();
        pool.delete();
        for (int i = 1; i < N; i++) pool.push_back(i);
        cur.delete();
        closed_list.delete();
        pub_list.delete();
        consumed.delete();
        closed    = 1'b0;
        pub_valid = 1'b0;
        ovf       = 1'b0;
        just_pub  = 1'b0;
    endtask

    task automatic model_step();
        int  pre_size = pool.size();
        bit  acc      = in_vld && !closed && (pre_size > 0);
        bit  pub      = closed && (!pub_valid || start_rdy);
        bit  take     = pub_valid && start_rdy;
        int  a;
        just_pub = 1'b0;
        if (take) begin
            foreach (pub_list[i]) consumed.push_back(pub_list[i]);
        end
        if (pub) begin
            pub_list  = closed_list;
            pub_valid = 1'b1;
            closed    = 1'b0;
            just_pub  = 1'b1;
        end else if (take) begin
            pub_valid = 1'b0;
        end
        if (acc) begin
            a = pool.pop_front();
            cur.push_back(a);
            if (in_last) begin
                closed_list = cur;
                cur.delete();
                closed = 1'b1;
            end
        end
        if (free_vld && free_ptr != 0) begin
            if (pre_size == N) ovf = 1'b1;
            else pool.push_back(int'(free_ptr));
        end
    endtask

    task automatic check_all();
        bit exp_rdy = !closed && (pool.size() > 0);
        check_eq("in_rdy", in_rdy, exp_rdy);
        if (exp_rdy) check_eq("alloc_ptr", alloc_ptr, pool[0]);
        check_eq("free_cnt", free_cnt, pool.size());
        check_eq("start_vld", start_vld, pub_valid);
        if (pub_valid) check_eq("start", start, pub_list[0]);
        check_eq("err_overflow", err_overflow, ovf);
        if (just_pub) begin
            for (int i = 0; i < pub_list.size(); i++) begin
                check_eq("chain_link", tbl[pub_list[i]],
                         (i + 1 < pub_list.size()) ? pub_list[i+1] : 0);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input bit vld, input bit last, input bit srdy,
                         input bit fv, input int fp);
        in_vld    = vld;
        in_last   = last;
        start_rdy = srdy;
        free_vld  = fv;
        free_ptr  = W'(fp);
        cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_vld = 0; in_last = 0; start_rdy = 0; free_vld = 0; free_ptr = '0;
        @(negedge clk);
        do_reset();
        drive(0, 0, 0, 0, 0);

        // three-node list, walker not ready until later
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0);

        // single-node list
        drive(1, 1, 1, 0, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0);

        // backpressure: second list waits in TERM until one start_rdy pulse
        drive(1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0);

        // null free is ignored
        drive(0, 0, 0, 1, 0);

        // pool exhaustion, then simultaneous beat and free at empty pool
        do_reset();
        for (int i = 0; i < 15; i++) drive(1, 0, 1, 0, 0);
        drive(1, 0, 1, 1, 5);
        drive(1, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0);

        // overflow is sticky until reset
        do_reset();
        drive(0, 0, 1, 1, 7);
        drive(0, 0, 1, 1, 9);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0);
        do_reset();
        drive(0, 0, 1, 0, 0);

        // reset in the middle of an open list
        drive(1, 0, 1, 0, 0);
        drive(1, 0, 1, 0, 0);
        do_reset();
        drive(0, 0, 1, 0, 0);

        // random traffic; only nodes of consumed lists are returned
        for (int i = 0; i < 2000; i++) begin
            bit vld  = ($urandom % 4) != 0;
            bit last = ($urandom % 4) == 0;
            bit srdy = $urandom % 2;
            bit fv   = 1'b0;
            int fp   = 0;
            if (consumed.size() > 0 && ($urandom % 2) == 1) begin
                fv = 1'b1;
                fp = consumed.pop_front();
            end else if (($urandom % 16) == 0) begin
                fv = 1'b1;
            end
            drive(vld, last, srdy, fv, fp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
